// File: rtl/instr_register_pkg.sv
// ----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for instr_register and its front-end scheduler.
//   opcode_t, operand_t, address_t, instruction_t : register-file data types
//   sched_state_t                                 : scheduler FSM states
//   SCHED_DEPTH, SCHED_NUM_REQ                    : scheduler defaults
//   ptr_inc()                                     : circular pointer increment
// ----------------------------------------------------------------------------
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef logic [4:0] address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    localparam int unsigned SCHED_DEPTH   = 32;
    localparam int unsigned SCHED_NUM_REQ = 2;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } sched_state_t;

    // Pointer width equals log2 of the depth, so wrap-around is implicit.
    function automatic address_t ptr_inc(input address_t p);
        return p + address_t'(1);
    endfunction

endpackage

// File: rtl/instr_reg_scheduler_rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. Grant is combinational; the last winner is
// registered so that on a tie the other requester wins next.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   req_i          : request vector
//   enable_i       : grants are allowed this cycle
//   grant_o        : one-hot grant (or zero)
// ----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    logic rr_last_q, rr_last_d;

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            unique case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = rr_last_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
        rr_last_d = rr_last_q;
        if (grant_o != 2'b00) begin
            rr_last_d = grant_o[1];
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/instr_reg_scheduler.sv
// ----------------------------------------------------------------------------
// instr_reg_scheduler
// Sequencer/arbiter in front of instr_register: shares the write port between
// two producers (round-robin), keeps write/read pointers as a circular queue,
// serves one consumer with a registered read, and can flush the register file.
//   clk, reset             : clock, asynchronous active-high reset
//   req_valid/req_ready    : per-requester handshake (ready = granted)
//   req_opcode/_operand_*  : per-requester instruction fields
//   flush                  : clear queue and pulse reg_reset_n
//   rd_req/rd_valid/rd_instr : consumer read, 1-cycle latency
//   full, empty            : occupancy flags
//   load_en, reg_reset_n, opcode, operand_a, operand_b,
//   write_pointer, read_pointer, instruction_word : instr_register interface
// Optional: define INSTR_SCHED_STATS_EN to add stat_grants (saturating
// per-requester accepted-write counters).
// ----------------------------------------------------------------------------
module instr_reg_scheduler
    import instr_register_pkg::*;
#(
    parameter int unsigned NUM_REQ = SCHED_NUM_REQ,
    parameter int unsigned DEPTH   = SCHED_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  opcode_t            req_opcode    [NUM_REQ],
    input  operand_t           req_operand_a [NUM_REQ],
    input  operand_t           req_operand_b [NUM_REQ],
    input  logic               flush,
    input  logic               rd_req,
    output logic               rd_valid,
    output instruction_t       rd_instr,
    output logic               full,
    output logic               empty,
    output logic               load_en,
    output logic               reg_reset_n,
    output opcode_t            opcode,
    output operand_t           operand_a,
    output operand_t           operand_b,
    output address_t           write_pointer,
    output address_t           read_pointer,
    input  instruction_t       instruction_word
`ifdef INSTR_SCHED_STATS_EN
    ,
    output logic [15:0]        stat_grants [NUM_REQ]
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    sched_state_t   state_q, state_d;
    address_t       wr_ptr_q, wr_ptr_d;
    address_t       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           rd_valid_q, rd_valid_d;
    instruction_t   rd_instr_q, rd_instr_d;

    logic [1:0] grant;
    logic       run, arb_en, wr_en, rd_en;

    assign run   = (state_q == RUN);
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Flush wins over same-cycle writes/reads; grant uses the registered full,
    // so a read from a full queue does not free a slot in the same cycle.
    assign arb_en = run && !flush && !full && !reset;
    assign rd_en  = run && !flush && rd_req && !empty && !reset;
    assign wr_en  = (grant != 2'b00);

    rr_arbiter2 u_arb (
        .clk_i    (clk),
        .reset_i  (reset),
        .req_i    (req_valid[1:0]),
        .enable_i (arb_en),
        .grant_o  (grant)
    );

    assign req_ready     = grant;
    assign load_en       = wr_en;
    assign opcode        = grant[1] ? req_opcode[1]    : req_opcode[0];
    assign operand_a     = grant[1] ? req_operand_a[1] : req_operand_a[0];
    assign operand_b     = grant[1] ? req_operand_b[1] : req_operand_b[0];
    assign write_pointer = wr_ptr_q;
    assign read_pointer  = rd_ptr_q;
    assign rd_valid      = rd_valid_q;
    assign rd_instr      = rd_instr_q;
    assign reg_reset_n   = !reset && (state_q != FLUSH);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_en;
        rd_instr_d = rd_instr_q;

        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_en) begin
            rd_instr_d = instruction_word;
            rd_ptr_d   = ptr_inc(rd_ptr_q);
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d  = RECOVER;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_instr_q <= rd_instr_d;
        end
    end

`ifdef INSTR_SCHED_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [15:0] stat_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stat_q <= '0;
            end else if (state_q == FLUSH) begin
                stat_q <= '0;
            end else if (grant[i] && (stat_q != 16'hFFFF)) begin
                stat_q <= stat_q + 16'd1;
            end
        end

        assign stat_grants[i] = stat_q;
    end
`endif

endmodule
